// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: MIPS memory opcodes,
// controller state encoding, access size and the opcode decode helper.
package mem_access_ctrl_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      legal;
    logic      is_load;
    logic      is_store;
    logic      sign_ext;
    acc_size_e size;
  } op_decode_t;

  // Classify an opcode; anything outside the eight memory opcodes is illegal.
  function automatic op_decode_t decode_op(input logic [5:0] opcode);
    op_decode_t d;
    d = '{legal: 1'b0, is_load: 1'b0, is_store: 1'b0, sign_ext: 1'b0, size: SIZE_BYTE};
    case (opcode)
      OPCODE_LB:  begin d.legal = 1'b1; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SIZE_BYTE; end
      OPCODE_LH:  begin d.legal = 1'b1; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SIZE_HALF; end
      OPCODE_LW:  begin d.legal = 1'b1; d.is_load = 1'b1; d.size = SIZE_WORD; end
      OPCODE_LBU: begin d.legal = 1'b1; d.is_load = 1'b1; d.size = SIZE_BYTE; end
      OPCODE_LHU: begin d.legal = 1'b1; d.is_load = 1'b1; d.size = SIZE_HALF; end
      OPCODE_SB:  begin d.legal = 1'b1; d.is_store = 1'b1; d.size = SIZE_BYTE; end
      OPCODE_SH:  begin d.legal = 1'b1; d.is_store = 1'b1; d.size = SIZE_HALF; end
      OPCODE_SW:  begin d.legal = 1'b1; d.is_store = 1'b1; d.size = SIZE_WORD; end
      default:    ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus Avalon-style data bus signals.
// The master modport is the controller (it masters the data bus); the slave
// modport is the surrounding CPU/bus environment.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    input  req_valid, req_opcode, req_addr, req_wdata, readdata, waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, byteenable, writedata
  );

  modport slave (
    output req_valid, req_opcode, req_addr, req_wdata, readdata, waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mem_access_ctrl_store_lane_pack.sv
// Combinational lane mapper: turns (opcode, low address bits, store data)
// into bus byte enables, lane-replicated write data and a misalignment flag.
module store_lane_pack
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misaligned
);

  // Lane enables apply to loads and stores alike; only stores carry data.
  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0;
    misaligned = 1'b0;
    case (opcode)
      OPCODE_LB, OPCODE_LBU: begin
        byteenable = 4'b0001 << addr_lo;
      end
      OPCODE_SB: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
      end
      OPCODE_LH, OPCODE_LHU: begin
        misaligned = addr_lo[0];
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      OPCODE_SH: begin
        misaligned = addr_lo[0];
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
      end
      OPCODE_LW: begin
        misaligned = |addr_lo;
        byteenable = 4'b1111;
      end
      OPCODE_SW: begin
        misaligned = |addr_lo;
        byteenable = 4'b1111;
        writedata  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer between the CPU memory stage and
// the data bus: accepts one request, runs one bus cycle (held through
// waitrequest, abandoned on timeout) and returns a one-cycle response.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic              clk,
  input logic              reset_n,
  mem_access_ctrl_if.master mif
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_BUS  = 2'(ST_BUS);
  localparam logic [1:0] S_RESP = 2'(ST_RESP);
  localparam logic [1:0] S_ERR  = 2'(ST_ERR);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [5:0]       op_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             timeout_hit;
  logic             accept;

  logic [5:0]       dec_op;
  op_decode_t       dec;

  logic [3:0]       pack_be;
  logic [31:0]      pack_wd;
  logic             pack_mis;

  logic [7:0]       rd_lane [4];
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_data;

  assign mif.req_ready = (state == S_IDLE);
  assign accept        = mif.req_valid && mif.req_ready;

  // In IDLE the decode looks at the incoming request, afterwards at the latched one.
  assign dec_op = (state == S_IDLE) ? mif.req_opcode : op_q;
  assign dec    = decode_op(dec_op);

  store_lane_pack u_pack (
    .opcode     (mif.req_opcode),
    .addr_lo    (mif.req_addr[1:0]),
    .wdata      (mif.req_wdata),
    .byteenable (pack_be),
    .writedata  (pack_wd),
    .misaligned (pack_mis)
  );

  // Split readdata into its little-endian byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_lane[gi] = mif.readdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_lane[lane_q];
  assign sel_half = lane_q[1] ? mif.readdata[31:16] : mif.readdata[15:0];

  // Select and extend the addressed load lane(s).
  always_comb begin
    load_data = mif.readdata;
    case (dec.size)
      SIZE_BYTE: load_data = {{24{dec.sign_ext & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data = {{16{dec.sign_ext & sel_half[15]}}, sel_half};
      default:   load_data = mif.readdata;
    endcase
  end

  // A zero TIMEOUT_CYCLES never matches, so the stall wait is unbounded.
  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_LIMIT);

  // Controller FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op_q           <= 6'h0;
      lane_q         <= 2'b00;
      wait_cnt       <= '0;
      mif.address    <= 32'h0;
      mif.read       <= 1'b0;
      mif.write      <= 1'b0;
      mif.byteenable <= 4'b0000;
      mif.writedata  <= 32'h0;
      mif.resp_valid <= 1'b0;
      mif.resp_err   <= 1'b0;
      mif.resp_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= mif.req_opcode;
            lane_q   <= mif.req_addr[1:0];
            wait_cnt <= '0;
            if (!dec.legal || pack_mis) begin
              // Rejected up front: no bus cycle, straight to the error response.
              state          <= S_ERR;
              mif.resp_valid <= 1'b1;
              mif.resp_err   <= 1'b1;
              mif.resp_rdata <= 32'h0;
            end else begin
              state          <= S_BUS;
              mif.address    <= {mif.req_addr[31:2], 2'b00};
              mif.byteenable <= pack_be;
              mif.writedata  <= pack_wd;
              mif.read       <= dec.is_load;
              mif.write      <= dec.is_store;
            end
          end
        end
        S_BUS: begin
          if (!mif.waitrequest) begin
            state          <= S_RESP;
            mif.read       <= 1'b0;
            mif.write      <= 1'b0;
            mif.byteenable <= 4'b0000;
            mif.writedata  <= 32'h0;
            wait_cnt       <= '0;
            mif.resp_valid <= 1'b1;
            mif.resp_err   <= 1'b0;
            mif.resp_rdata <= dec.is_load ? load_data : 32'h0;
          end else if (timeout_hit) begin
            state          <= S_ERR;
            mif.read       <= 1'b0;
            mif.write      <= 1'b0;
            mif.byteenable <= 4'b0000;
            mif.writedata  <= 32'h0;
            wait_cnt       <= '0;
            mif.resp_valid <= 1'b1;
            mif.resp_err   <= 1'b1;
            mif.resp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        S_RESP, S_ERR: begin
          state          <= S_IDLE;
          wait_cnt       <= '0;
          mif.resp_valid <= 1'b0;
          mif.resp_err   <= 1'b0;
          mif.resp_rdata <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized accesses
// against a reference model, plus reset, timeout and back-to-back sequences.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if m_if();
  mem_access_ctrl_if t_if();

  mem_access_ctrl #(.TIMEOUT_CYCLES(1024), .CNT_W(11)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mif     (m_if)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk     (clk),
    .reset_n (reset_n),
    .mif     (t_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          rd_cyc;
    int          wr_cyc;
  } vec_t;

  typedef struct {
    int          resp_cnt;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        stable;
    logic        ready_low;
  } res_t;

  typedef struct {
    logic        err;
    logic        load;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: access rules computed arithmetically from size and byte lane.
  function automatic exp_t ref_model(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    int size;
    int lane;
    bit sgn;
    bit ok;
    logic [31:0] mask;
    logic [31:0] val;
    e = '{err: 1'b0, load: 1'b0, be: 4'h0, wd: 32'h0, rd: 32'h0};
    ok = 1; sgn = 0; size = 1;
    case (op)
      OPCODE_LB:  begin size = 1; sgn = 1; e.load = 1'b1; end
      OPCODE_LBU: begin size = 1; e.load = 1'b1; end
      OPCODE_LH:  begin size = 2; sgn = 1; e.load = 1'b1; end
      OPCODE_LHU: begin size = 2; e.load = 1'b1; end
      OPCODE_LW:  begin size = 4; e.load = 1'b1; end
      OPCODE_SB:  size = 1;
      OPCODE_SH:  size = 2;
      OPCODE_SW:  size = 4;
      default:    ok = 0;
    endcase
    lane = int'(addr % 4);
    if (!ok || (lane % size) != 0) begin
      e.err = 1'b1;
      e.load = 1'b0;
      return e;
    end
    e.be = 4'(((1 << size) - 1) << lane);
    if (e.load) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (rdata >> (8 * lane)) & mask;
      if (sgn && val[8 * size - 1]) val = val | ~mask;
      e.rd = val;
    end else begin
      for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = wdata[8*(k % size) +: 8];
    end
    return e;
  endfunction

  // One request on m_if: waits stall cycles, then observe strobes and response.
  task automatic run_access(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, output res_t r);
    int guard;
    bit first;
    r = '{resp_cnt: 0, lat: -1, err: 1'b0, rdata: 32'h0, rd_cyc: 0, wr_cyc: 0,
          addr: 32'h0, be: 4'h0, wd: 32'h0, stable: 1'b1, ready_low: 1'b1};
    guard = 0;
    @(negedge clk);
    while (!m_if.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(m_if.req_ready), 32'd1);
    m_if.req_valid   = 1'b1;
    m_if.req_opcode  = op;
    m_if.req_addr    = addr;
    m_if.req_wdata   = wdata;
    m_if.readdata    = rdata;
    m_if.waitrequest = 1'b0;
    @(negedge clk);
    m_if.req_valid = 1'b0;
    first = 1;
    for (int c = 1; c <= waits + 6; c++) begin
      m_if.waitrequest = (c <= waits);
      if (c == 1 && m_if.req_ready) r.ready_low = 1'b0;
      if (m_if.read || m_if.write) begin
        if (m_if.read)  r.rd_cyc++;
        if (m_if.write) r.wr_cyc++;
        if (first) begin
          r.addr = m_if.address; r.be = m_if.byteenable; r.wd = m_if.writedata;
          first = 0;
        end else if (m_if.address !== r.addr || m_if.byteenable !== r.be ||
                     m_if.writedata !== r.wd) begin
          r.stable = 1'b0;
        end
      end
      if (m_if.resp_valid) begin
        r.resp_cnt++;
        if (r.lat < 0) begin
          r.lat = c; r.err = m_if.resp_err; r.rdata = m_if.resp_rdata;
        end
      end
      @(negedge clk);
    end
    m_if.waitrequest = 1'b0;
    $display("txn op=%02h addr=%08h waits=%0d resp_err=%0b rdata=%08h lat=%0d be=%b",
             op, addr, waits, r.err, r.rdata, r.lat, r.be);
  endtask

  task automatic check_result(input string tag, input vec_t v, input res_t r);
    chk({tag, "_resp_cnt"}, 32'(r.resp_cnt), 32'd1);
    chk({tag, "_lat"},      32'(r.lat),      32'(v.lat));
    chk({tag, "_err"},      32'(r.err),      32'(v.err));
    chk({tag, "_rdata"},    r.rdata,         v.rd);
    chk({tag, "_rd_cyc"},   32'(r.rd_cyc),   32'(v.rd_cyc));
    chk({tag, "_wr_cyc"},   32'(r.wr_cyc),   32'(v.wr_cyc));
    chk({tag, "_ready_low"}, 32'(r.ready_low), 32'd1);
    if (v.rd_cyc + v.wr_cyc > 0) begin
      chk({tag, "_address"}, r.addr, {v.addr[31:2], 2'b00});
      chk({tag, "_be"},      32'(r.be), 32'(v.be));
      chk({tag, "_wd"},      r.wd, v.wd);
      chk({tag, "_stable"},  32'(r.stable), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    res_t r;
    exp_t e;
    vec_t v;
    logic [5:0] ops[9];
    logic [8:0] resp_mask;
    logic [8:0] read_mask;
    int resp_seen;
    int rd_seen;
    int lat;
    logic err_seen;
    logic [31:0] rdata_seen;

    tbl[0]  = '{OPCODE_LW,  32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF, 2, 1, 0};
    tbl[1]  = '{OPCODE_LB,  32'h0000_1003, 32'h0,         32'h8011_2233, 0, 1'b0, 4'h8, 32'h0,         32'hFFFF_FF80, 2, 1, 0};
    tbl[2]  = '{OPCODE_LBU, 32'h0000_1003, 32'h0,         32'h8011_2233, 0, 1'b0, 4'h8, 32'h0,         32'h0000_0080, 2, 1, 0};
    tbl[3]  = '{OPCODE_LH,  32'h0000_2002, 32'h0,         32'h9ABC_1234, 0, 1'b0, 4'hC, 32'h0,         32'hFFFF_9ABC, 2, 1, 0};
    tbl[4]  = '{OPCODE_LHU, 32'h0000_2002, 32'h0,         32'h9ABC_1234, 0, 1'b0, 4'hC, 32'h0,         32'h0000_9ABC, 2, 1, 0};
    tbl[5]  = '{OPCODE_SH,  32'h0000_2002, 32'h0000_BEEF, 32'h0,         0, 1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0,         2, 0, 1};
    tbl[6]  = '{OPCODE_SB,  32'h0000_3001, 32'h0000_00AB, 32'h0,         5, 1'b0, 4'h2, 32'hABAB_ABAB, 32'h0,         7, 0, 6};
    tbl[7]  = '{OPCODE_LW,  32'h0000_4002, 32'h0,         32'h1111_1111, 0, 1'b1, 4'h0, 32'h0,         32'h0,         1, 0, 0};
    tbl[8]  = '{6'h3F,      32'h0000_4000, 32'h0,         32'h1111_1111, 0, 1'b1, 4'h0, 32'h0,         32'h0,         1, 0, 0};
    tbl[9]  = '{OPCODE_SW,  32'h0000_5004, 32'h1234_5678, 32'h0,         2, 1'b0, 4'hF, 32'h1234_5678, 32'h0,         4, 0, 3};
    tbl[10] = '{OPCODE_LH,  32'h0000_2001, 32'h0,         32'h5555_5555, 0, 1'b1, 4'h0, 32'h0,         32'h0,         1, 0, 0};
    tbl[11] = '{OPCODE_LB,  32'h0000_2000, 32'h0,         32'h0000_007F, 1, 1'b0, 4'h1, 32'h0,         32'h0000_007F, 3, 2, 0};
    tbl[12] = '{OPCODE_LHU, 32'h0000_2000, 32'h0,         32'h1234_F00D, 0, 1'b0, 4'h3, 32'h0,         32'h0000_F00D, 2, 1, 0};
    tbl[13] = '{OPCODE_SB,  32'h0000_3003, 32'h0000_00C5, 32'h0,         0, 1'b0, 4'h8, 32'hC5C5_C5C5, 32'h0,         2, 0, 1};

    ops = '{OPCODE_LB, OPCODE_LH, OPCODE_LW, OPCODE_LBU, OPCODE_LHU,
            OPCODE_SB, OPCODE_SH, OPCODE_SW, 6'h3F};

    // Reset state
    reset_n = 1'b0;
    m_if.req_valid = 1'b0; m_if.req_opcode = 6'h0; m_if.req_addr = 32'h0;
    m_if.req_wdata = 32'h0; m_if.readdata = 32'h0; m_if.waitrequest = 1'b0;
    t_if.req_valid = 1'b0; t_if.req_opcode = 6'h0; t_if.req_addr = 32'h0;
    t_if.req_wdata = 32'h0; t_if.readdata = 32'h0; t_if.waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(m_if.req_ready),  32'd1);
    chk("rst_read",       32'(m_if.read),       32'd0);
    chk("rst_write",      32'(m_if.write),      32'd0);
    chk("rst_resp_valid", 32'(m_if.resp_valid), 32'd0);
    chk("rst_address",    m_if.address,         32'h0);
    chk("rst_byteenable", 32'(m_if.byteenable), 32'd0);
    reset_n = 1'b1;

    // Directed vector table
    foreach (tbl[i]) begin
      run_access(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].waits, r);
      check_result($sformatf("vec%0d", i), tbl[i], r);
    end

    // Randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      v.op    = ops[$urandom_range(0, 8)];
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.waits = $urandom_range(0, 3);
      e = ref_model(v.op, v.addr, v.wdata, v.rdata);
      v.err    = e.err;
      v.be     = e.be;
      v.wd     = e.wd;
      v.rd     = e.rd;
      v.lat    = e.err ? 1 : v.waits + 2;
      v.rd_cyc = (!e.err && e.load)  ? v.waits + 1 : 0;
      v.wr_cyc = (!e.err && !e.load) ? v.waits + 1 : 0;
      run_access(v.op, v.addr, v.wdata, v.rdata, v.waits, r);
      check_result($sformatf("rnd%0d", n), v, r);
    end

    // Back-to-back: request held high, zero wait states
    @(negedge clk);
    m_if.req_valid = 1'b1; m_if.req_opcode = OPCODE_LW; m_if.req_addr = 32'h0000_7000;
    m_if.readdata = 32'hCAFE_F00D; m_if.waitrequest = 1'b0;
    resp_mask = '0; read_mask = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      resp_mask[c-1] = m_if.resp_valid;
      read_mask[c-1] = m_if.read;
      if (c == 9) m_if.req_valid = 1'b0;
    end
    $display("txn back_to_back resp_mask=%b read_mask=%b", resp_mask, read_mask);
    chk("b2b_resp_mask", 32'(resp_mask), 32'h092);
    chk("b2b_read_mask", 32'(read_mask), 32'h049);

    // Reset asserted mid-access during a stalled store
    @(negedge clk);
    m_if.req_valid = 1'b1; m_if.req_opcode = OPCODE_SW; m_if.req_addr = 32'h0000_6000;
    m_if.req_wdata = 32'h1122_3344; m_if.waitrequest = 1'b1;
    @(negedge clk);
    m_if.req_valid = 1'b0;
    chk("rst_mid_write_before", 32'(m_if.write), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_write",      32'(m_if.write),      32'd0);
    chk("rst_mid_byteenable", 32'(m_if.byteenable), 32'd0);
    chk("rst_mid_writedata",  m_if.writedata,       32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_if.waitrequest = 1'b0;
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_if.resp_valid) resp_seen++;
    end
    $display("txn reset_mid_access resp_seen=%0d req_ready=%0b", resp_seen, m_if.req_ready);
    chk("rst_mid_no_resp",   32'(resp_seen),       32'd0);
    chk("rst_mid_req_ready", 32'(m_if.req_ready),  32'd1);

    // Timeout with waitrequest stuck high (TIMEOUT_CYCLES = 4)
    @(negedge clk);
    t_if.req_valid = 1'b1; t_if.req_opcode = OPCODE_LW; t_if.req_addr = 32'h0000_5000;
    t_if.readdata = 32'h1234_5678; t_if.waitrequest = 1'b1;
    rd_seen = 0; resp_seen = 0; lat = -1; err_seen = 1'b0; rdata_seen = 32'hFFFF_FFFF;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      t_if.req_valid = 1'b0;
      if (t_if.read) rd_seen++;
      if (t_if.resp_valid) begin
        resp_seen++;
        if (lat < 0) begin
          lat = c; err_seen = t_if.resp_err; rdata_seen = t_if.resp_rdata;
        end
      end
    end
    t_if.waitrequest = 1'b0;
    $display("txn timeout read_cycles=%0d resp_err=%0b lat=%0d", rd_seen, err_seen, lat);
    chk("to_read_cycles", 32'(rd_seen),   32'd4);
    chk("to_resp_cnt",    32'(resp_seen), 32'd1);
    chk("to_lat",         32'(lat),       32'd5);
    chk("to_err",         32'(err_seen),  32'd1);
    chk("to_rdata",       rdata_seen,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences one CPU load/store at a time onto the Avalon-style data bus.
- Accepts a request (opcode, byte address, store data) over a valid/ready handshake.
- Checks alignment and opcode legality.
- Drives word-aligned address, byteenable and lane-replicated writedata, and holds them through waitrequest.
- Extracts and extends load lanes, and returns a single-cycle response with data or error.
- Sits between the CPU memory stage and the data bus master port.

Parameters:
TIMEOUT_CYCLES, 1024, waitrequest cycles tolerated before the access is abandoned with error; 0 disables the timeout.
CNT_W, 11, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept (IDLE only)
req_opcode  in  6  MIPS opcode: LB, LH, LW, LBU, LHU, SB, SH, SW
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half/word used
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: misaligned, illegal opcode or timeout
address  out  32  bus word address, {req_addr[31:2], 2'b00}
read  out  1  bus read strobe
write  out  1  bus write strobe
byteenable  out  4  bus lane enables
writedata  out  32  bus write data
readdata  in  32  bus read data, little-endian lanes (lane k = bits 8k+7:8k)
waitrequest  in  1  bus stall

Behaviour:
- Reset (asynchronous, immediate, also mid-access):
  - state = IDLE.
  - read, write, resp_valid and resp_err = 0.
  - address, byteenable, writedata and resp_rdata = 0.
  - Timeout counter = 0.
  - An in-flight access is dropped, with no response.
- States: IDLE, BUS, RESP, ERR.
- IDLE:
  - req_ready = 1; all bus strobes low.
  - On req_valid && req_ready, latch opcode, addr[1:0] and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or illegal opcode -> ERR. No bus cycle is issued.
  - Otherwise -> BUS.
- BUS:
  - read = 1 for loads, write = 1 for stores. address, byteenable and writedata are registered and held stable while waitrequest = 1.
  - When waitrequest = 0: for loads, capture the extended readdata into resp_rdata; go to RESP.
  - Timeout counter increments on each BUS cycle with waitrequest = 1. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, drop the strobes and go to ERR.
  - The timeout check takes priority only when waitrequest is still 1 in that cycle.
- RESP: resp_valid = 1, resp_err = 0 for exactly one cycle; go to IDLE. Counter cleared.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0 for one cycle; go to IDLE.
- Latency: accept edge -> BUS for at least 1 cycle -> RESP. With zero wait states, resp_valid is seen 2 cycles after the accept edge. An error detected at accept gives resp_valid 1 cycle after accept.
- req_ready is 0 in BUS, RESP and ERR. A back-to-back request can be accepted the cycle after RESP/ERR, so accepted requests are spaced at least 3 cycles apart with zero wait states.
- Store lane mapping:
  - SB: byteenable = 1<<a[1:0], writedata = {4{wdata[7:0]}}.
  - SH: byteenable = 4'b0011 (a[1]=0) or 4'b1100 (a[1]=1), writedata = {2{wdata[15:0]}}.
  - SW: byteenable = 4'b1111, writedata = wdata.
- Loads:
  - byteenable follows the same lane mapping as stores; writedata = 0.
  - LB and LH sign-extend from the selected byte or half; LBU and LHU zero-extend; LW passes readdata through.
  - An LH/LHU with a[1]=1 selects readdata[31:16].
- Simultaneous events: req_valid held high while not ready is ignored (no queueing). The CPU must hold the request until accepted.

Decomposition:
- Shared package: the OPCODE_LB/LH/LW/LBU/LHU/SB/SH/SW constants (already present), a new state enum typedef for the controller, and an is_load/is_store/size decode function.
- One sub-module, store_lane_pack: combinational map of (opcode, addr[1:0], wdata) to (byteenable, writedata, misaligned).
- Load extraction lives inside the controller.

Test Plan:
- LW 0x1000, readdata=0xDEADBEEF, waitrequest=0 -> read=1 for 1 cycle, address=0x1000, byteenable=1111; resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF.
- LB 0x1003 and LBU 0x1003 with readdata=0x80112233 -> byteenable=1000; resp_rdata=0xFFFFFF80 and 0x00000080 respectively.
- LH and LHU at 0x2002 with readdata=0x9ABC1234 -> byteenable=1100; resp_rdata=0xFFFF9ABC and 0x00009ABC. Also SH 0x2002, wdata=0x0000BEEF -> writedata=0xBEEFBEEF, byteenable=1100.
- SB 0x3001, wdata=0xAB, waitrequest high for 5 cycles -> write, address, byteenable=0010 and writedata=0xABABABAB held stable for all 6 BUS cycles; one resp_valid, resp_err=0.
- LW 0x4002, then an opcode-0x3F request -> no read/write asserted; resp_valid with resp_err=1 the cycle after each accept. With TIMEOUT_CYCLES=4 and waitrequest stuck at 1 -> strobes drop and resp_err=1.
- reset_n pulsed low during BUS on a write -> write and byteenable go to 0 asynchronously; no resp_valid; req_ready=1 after release.
